alu8_rr_sched: RTL

Round-robin scheduler that shares one `alu8` combinational datapath among `NUM_REQ` independent requesters. Each requester presents an operation (a, b, op) with a valid/ready handshake. The block grants one requester at a time and registers the operands. It evaluates them through a single `alu8` instance and returns the registered result on a shared response channel, tagged with the requester ID. It sits between the command-issuing agents and the ALU, so that no requester drives the ALU directly.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu8_rr_sched_alu8.sv | 35 +++
 rtl/alu8_rr_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit ALU and its round-robin scheduler.
package alu_pkg;

  localparam int ALU_W = 8;

  // ALU opcode encoding; all eight codes are legal.
  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SLT = 3'd5,
    SHL = 3'd6,
    SHR = 3'd7
  } alu_op_e;

  // Scheduler phases: arbitrate, evaluate, hand back the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  // Only the arithmetic ops report a carry/borrow out of bit ALU_W.
  function automatic logic alu_has_carry(input alu_op_e op);
    return (op == ADD) || (op == SUB);
  endfunction

endpackage

// File: rtl/alu8_rr_sched_alu8.sv
// Purely combinational 8-bit ALU. Shifts move by one bit and ignore b.
// SLT compares unsigned, matching the unsigned borrow of SUB.
module alu8
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  alu_op_e          op,
  output logic [ALU_W-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [ALU_W:0] wide;

  // Evaluate the selected operation on a 9-bit path so add/sub expose bit 8.
  always_comb begin
    wide = '0;
    case (op)
      ADD:     wide = {1'b0, a} + {1'b0, b};
      SUB:     wide = {1'b0, a} - {1'b0, b};
      AND:     wide = {1'b0, a & b};
      OR:      wide = {1'b0, a | b};
      XOR:     wide = {1'b0, a ^ b};
      SLT:     wide = {{ALU_W{1'b0}}, (a < b)};
      SHL:     wide = {1'b0, a[ALU_W-2:0], 1'b0};
      SHR:     wide = {2'b00, a[ALU_W-1:1]};
      default: wide = '0;
    endcase
    result = wide[ALU_W-1:0];
    carry  = alu_has_carry(op) ? wide[ALU_W] : 1'b0;
    zero   = (wide[ALU_W-1:0] == {ALU_W{1'b0}});
  end

endmodule

// File: rtl/alu8_rr_sched.sv
// Round-robin scheduler sharing one alu8 among NUM_REQ requesters.
// One command is in flight at a time: IDLE grants, EXEC evaluates, RESP
// holds the tagged result until the consumer accepts it.
module alu8_rr_sched
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*ALU_W-1:0] req_a,
  input  logic [NUM_REQ*ALU_W-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [ALU_W-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_zero,
  output logic                     busy
);

  sched_state_e     state;
  sched_state_e     state_next;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  winner;
  logic             any_valid;
  logic             accept;
  logic             rsp_fire;
  logic [ALU_W-1:0] sel_a;
  logic [ALU_W-1:0] sel_b;
  logic [2:0]       sel_op;
  logic [ALU_W-1:0] op_a;
  logic [ALU_W-1:0] op_b;
  alu_op_e          op_code;
  logic [ID_W-1:0]  op_id;
  logic [ALU_W-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;

  // First valid requester strictly after 'last', wrapping NUM_REQ-1 -> 0.
  // The sum last+k never exceeds 2*NUM_REQ-1, so one subtraction wraps it.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [ID_W-1:0]    last);
    logic [ID_W:0]   cand;
    logic [ID_W-1:0] pick;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end else begin
        cand = cand;
      end
      if (!found && valid[cand[ID_W-1:0]]) begin
        pick  = cand[ID_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  assign any_valid = |req_valid;
  assign winner    = rr_pick(req_valid, last_grant);
  assign accept    = (state == IDLE) && any_valid;
  assign rsp_fire  = (state == RESP) && rsp_ready;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Route the winning requester's payload towards the operand registers.
  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        sel_a  = req_a[i*ALU_W +: ALU_W];
        sel_b  = req_b[i*ALU_W +: ALU_W];
        sel_op = req_op[i*3 +: 3];
      end else begin
        sel_a  = sel_a;
        sel_b  = sel_b;
        sel_op = sel_op;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the combinational grant; no grant while in reset.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    if (rst) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            req_ready[winner] = 1'b1;
            state_next        = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
        EXEC:    state_next = RESP;
        RESP: begin
          if (rsp_ready) begin
            state_next = IDLE;
          end else begin
            state_next = RESP;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Capture the granted command; the ALU only ever sees these registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_code <= ADD;
      op_id   <= '0;
    end else if (accept) begin
      op_a    <= sel_a;
      op_b    <= sel_b;
      op_code <= alu_op_e'(sel_op);
      op_id   <= winner;
    end
  end

  alu8 u_alu8 (
    .a      (op_a),
    .b      (op_b),
    .op     (op_code),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Register the ALU outcome at the end of EXEC; held unchanged through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_id     <= op_id;
      rsp_result <= alu_result;
      rsp_carry  <= alu_carry;
      rsp_zero   <= alu_zero;
    end
  end

  // Advance the round-robin pointer only once the response is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (rsp_fire) begin
      last_grant <= rsp_id;
    end
  end

endmodule
